envelope_adsr: RTL and testbench
================================

ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 SHALL have parameter width_p, default 12, giving the signed sample width.
REQ-002 SHALL have parameter env_width_p, default 8, giving the envelope level width (MAX = 2^env_width_p-1).
REQ-003 SHALL have parameter tick_div_p, default 12000, giving clock cycles per envelope tick (1 kHz at 12 MHz).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 gate_i  in  1  note held (high) / released (low).
REQ-007 attack_i, decay_i, release_i  in  env_width_p each  level step per tick for that phase.
REQ-008 sustain_i  in  env_width_p  sustain level.
REQ-009 valid_i  in  1, data_i  in  signed width_p, ready_o  out  1: input sample handshake from the waveform source.
REQ-010 valid_o  out  1, data_o  out  signed width_p, ready_i  in  1: output sample handshake to the sink.
REQ-011 env_o  out  env_width_p  current envelope level.
REQ-012 state_o  out  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
REQ-013 Tick counter SHALL count 0..tick_div_p-1 and wrap; tick is asserted for the one cycle where count = tick_div_p-1.
REQ-014 Registered gate_prev SHALL detect the gate rising edge (gate_i=1, gate_prev=0).
REQ-015 Gate rising edge in any state SHALL move to ATTACK next cycle, keeping the current level (retrigger, no reset to 0).
REQ-016 gate_i=0 in ATTACK, DECAY or SUSTAIN SHALL move to RELEASE next cycle, independent of tick.
REQ-017 Level changes SHALL occur only on tick cycles.
REQ-018 ATTACK on tick: level = min(level+attack_i, MAX); on reaching MAX, state SHALL become DECAY.
REQ-019 DECAY on tick: level = max(level-decay_i, sustain_i); on reaching sustain_i, state SHALL become SUSTAIN.
REQ-020 SUSTAIN on tick: level = sustain_i (tracks live changes).
REQ-021 RELEASE on tick: level = max(level-release_i, 0); on reaching 0, state SHALL become IDLE.
REQ-022 Add/subtract SHALL use env_width_p+1 bits and saturate; no wrap-around permitted.
REQ-023 A rate of 0 SHALL hold the level and stay in the current phase.
REQ-024 If a gate edge and a tick coincide, the gate transition SHALL win and the level SHALL NOT change that cycle.
REQ-025 ready_o SHALL equal (!valid_o | ready_i) combinationally.
REQ-026 On accept (valid_i & ready_o): data_o <= (data_i * {1'b0,level}) >>> env_width_p, signed, full-width product of width_p+env_width_p+1 bits, arithmetic shift; valid_o <= 1.
REQ-027 Level used in REQ-026 SHALL be the registered level on the accept cycle; latency is one cycle.
REQ-028 valid_o=1 & ready_i=0 SHALL hold data_o and valid_o stable.
REQ-029 Output fire without a new accept SHALL clear valid_o; simultaneous fire and accept SHALL load the new sample.
REQ-030 env_o and state_o SHALL be the registered level and state.

Reset
REQ-031 reset_i=1 SHALL set state IDLE, level 0, tick counter 0, gate_prev 0, valid_o 0, data_o 0; ready_o SHALL read 1.
REQ-032 Reset mid-operation SHALL abort any phase and discard a held output sample.

Verification (tick_div_p=4, env_width_p=8, width_p=12)
REQ-033 Reset pulse after activity -> state_o=0, env_o=0, valid_o=0, data_o=0, ready_o=1.
REQ-034 gate_i=1, attack_i=64 -> env_o 64,128,192,255 on successive ticks, then state_o=2.
REQ-035 decay_i=50, sustain_i=100 from 255 -> 205,155,105,100, then state_o=3; sustain_i changed to 90 -> env_o=90 next tick.
REQ-036 gate_i=0 at level 100, release_i=40 -> state_o=4 next cycle; env_o 60,20,0, then state_o=0.
REQ-037 Level 128, data_i=1000 -> data_o=500; data_i=-1000 -> data_o=-500; ready_i=0 -> data_o held, ready_o=0, no sample lost.
REQ-038 Gate rising at level 60 in RELEASE, coincident with tick -> state_o=1, env_o stays 60 that cycle, then 124 on next tick.

Source files
------------

// File: rtl/envelope_adsr.sv
// rtl/envelope_adsr.sv - ADSR envelope generator scaling a signed sample stream by the envelope level.
module envelope_adsr #(
  parameter int width_p     = 12,
  parameter int env_width_p = 8,
  parameter int tick_div_p  = 12000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          gate_i,
  input  logic [env_width_p-1:0]        attack_i,
  input  logic [env_width_p-1:0]        decay_i,
  input  logic [env_width_p-1:0]        sustain_i,
  input  logic [env_width_p-1:0]        release_i,
  input  logic                          valid_i,
  input  logic signed [width_p-1:0]     data_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic signed [width_p-1:0]     data_o,
  input  logic                          ready_i,
  output logic [env_width_p-1:0]        env_o,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int cnt_w_p  = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
  localparam int prod_w_p = width_p + env_width_p + 1;
  localparam logic [env_width_p-1:0] max_c = {env_width_p{1'b1}};

  state_t                    state_q, state_d;
  logic [env_width_p-1:0]    level_q, level_d;
  logic [cnt_w_p-1:0]        cnt_q, cnt_d;
  logic                      gate_prev_q;
  logic                      valid_q, valid_d;
  logic signed [width_p-1:0] data_q, data_d;

  logic                      tick;
  logic                      gate_rise;
  logic [env_width_p:0]      sum_att;
  logic [env_width_p:0]      dif_dec;
  logic [env_width_p:0]      dif_rel;
  logic                      accept;
  logic signed [prod_w_p-1:0] data_ext, lvl_ext, prod;
  logic                      unused_prod;

  assign tick      = (cnt_q == cnt_w_p'(tick_div_p - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign gate_rise = gate_i & ~gate_prev_q;

  // One extra bit exposes overflow (add) or borrow (subtract) for saturation.
  assign sum_att = {1'b0, level_q} + {1'b0, attack_i};
  assign dif_dec = {1'b0, level_q} - {1'b0, decay_i};
  assign dif_rel = {1'b0, level_q} - {1'b0, release_i};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (gate_rise) begin
      state_d = ATTACK;
    end else if (!gate_i && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: if (attack_i != '0) begin
          if (sum_att >= {1'b0, max_c}) begin
            level_d = max_c;
            state_d = DECAY;
          end else begin
            level_d = sum_att[env_width_p-1:0];
          end
        end
        DECAY: if (decay_i != '0) begin
          if (dif_dec[env_width_p] || (dif_dec[env_width_p-1:0] <= sustain_i)) begin
            level_d = sustain_i;
            state_d = SUSTAIN;
          end else begin
            level_d = dif_dec[env_width_p-1:0];
          end
        end
        SUSTAIN: level_d = sustain_i;
        RELEASE: if (release_i != '0) begin
          if (dif_rel[env_width_p] || (dif_rel[env_width_p-1:0] == '0)) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = dif_rel[env_width_p-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = ~valid_q | ready_i;
  assign accept   = valid_i & ready_o;
  assign data_ext = prod_w_p'(data_i);
  assign lvl_ext  = prod_w_p'($signed({1'b0, level_q}));
  assign prod     = data_ext * lvl_ext;
  // Low bits of the product fall below the shift and carry no output information.
  assign unused_prod = ^{prod[prod_w_p-1:env_width_p+width_p], prod[env_width_p-1:0]};

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = prod[env_width_p +: width_p];
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      level_q     <= '0;
      cnt_q       <= '0;
      gate_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      gate_prev_q <= gate_i;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign env_o   = level_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// tb/tb_envelope_adsr.sv - directed self-checking bench for envelope_adsr.
module tb_envelope_adsr;

  logic               clk = 1'b0;
  logic               reset;
  logic               gate;
  logic [7:0]         attack, decay, sustain, rel;
  logic               valid_in, ready_out, valid_out, ready_in;
  logic signed [11:0] data_in, data_out;
  logic [7:0]         env;
  logic [2:0]         state;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  envelope_adsr #(.width_p(12), .env_width_p(8), .tick_div_p(4)) dut (
    .clk_i(clk), .reset_i(reset), .gate_i(gate),
    .attack_i(attack), .decay_i(decay), .sustain_i(sustain), .release_i(rel),
    .valid_i(valid_in), .data_i(data_in), .ready_o(ready_out),
    .valid_o(valid_out), .data_o(data_out), .ready_i(ready_in),
    .env_o(env), .state_o(state)
  );

  always #5 clk = ~clk;

  // Independent copy of the tick period: phase 0 right after an edge means a tick edge just occurred.
  always @(posedge clk) phase <= reset ? 0 : (phase == 3 ? 0 : phase + 1);

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(phase == 0 && !reset) && n < 8);
    if (n >= 8) check("tick_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_env"}, int'(env), 0);
    check({tag, "_valid"}, int'(valid_out), 0);
    check({tag, "_data"}, int'(data_out), 0);
    check({tag, "_ready"}, int'(ready_out), 1);
  endtask

  initial begin
    int att_exp[4] = '{64, 128, 192, 255};
    int dec_exp[4] = '{205, 155, 105, 100};
    int rel_exp[3] = '{60, 20, 0};
    gate = 0; attack = 0; decay = 0; sustain = 0; rel = 0;
    valid_in = 0; data_in = 0; ready_in = 1;
    do_reset();
    check_reset("por");

    attack = 64; decay = 50; sustain = 100; rel = 40; gate = 1;
    step();
    check("rise_state", int'(state), 1);
    check("rise_env", int'(env), 0);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      check("attack_env", int'(env), att_exp[i]);
    end
    check("attack_done", int'(state), 2);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      check("decay_env", int'(env), dec_exp[i]);
    end
    check("decay_done", int'(state), 3);
    sustain = 90;
    wait_tick();
    check("sustain_track", int'(env), 90);
    sustain = 100;
    wait_tick();
    check("sustain_back", int'(env), 100);

    gate = 0;
    step();
    check("release_state", int'(state), 4);
    check("release_hold", int'(env), 100);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      check("release_env", int'(env), rel_exp[i]);
    end
    check("release_idle", int'(state), 0);

    // Retrigger from RELEASE at level 60, rising edge landing on a tick.
    attack = 100;
    gate = 1;
    step();
    wait_tick();
    check("att100_env", int'(env), 100);
    gate = 0;
    step();
    wait_tick();
    check("rel60_env", int'(env), 60);
    check("rel60_state", int'(state), 4);
    step(); step(); step();
    attack = 64;
    gate = 1;
    step();
    check("retrig_tick_phase", phase, 0);
    check("retrig_state", int'(state), 1);
    check("retrig_env", int'(env), 60);
    wait_tick();
    check("retrig_next", int'(env), 124);

    // Sample path at level 128, with a zero attack rate holding the level.
    gate = 0;
    do_reset();
    gate = 1;
    step();
    wait_tick();
    wait_tick();
    check("lvl128", int'(env), 128);
    attack = 0;
    wait_tick();
    check("rate0_env", int'(env), 128);
    check("rate0_state", int'(state), 1);

    valid_in = 1; data_in = 1000; ready_in = 1;
    step();
    check("pos_valid", int'(valid_out), 1);
    check("pos_data", int'(data_out), 500);
    data_in = -1000;
    step();
    check("neg_data", int'(data_out), -500);
    data_in = 300; ready_in = 0;
    #1;
    check("bp_ready", int'(ready_out), 0);
    step();
    check("bp_hold_data", int'(data_out), -500);
    check("bp_hold_valid", int'(valid_out), 1);
    ready_in = 1;
    step();
    check("bp_release", int'(data_out), 150);
    valid_in = 0;
    step();
    check("drain_valid", int'(valid_out), 0);

    valid_in = 1; data_in = 1000; ready_in = 0;
    step();
    check("held_before_rst", int'(data_out), 500);
    valid_in = 0; ready_in = 1;
    do_reset();
    #1;
    check_reset("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
